// File: rtl/skin_bbox_overlay.sv
// skin_bbox_overlay: tracks the bounding box of marker-coloured pixels in each
// frame and draws that box's outline over the following frame. All video
// outputs are registered with a fixed one-cycle latency.
// Optional feature: define SKIN_BBOX_CROSSHAIR_EN to also draw a centre
// crosshair inside a valid box.
module skin_bbox_overlay #(
  parameter int          X_BITS      = 11,
  parameter int          Y_BITS      = 11,
  parameter logic [23:0] MARK_COLOUR = 24'hFFFFFF,
  parameter logic [23:0] BOX_COLOUR  = 24'hFF0000,
  parameter int          MIN_PIXELS  = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [23:0] i_vid_data,
  input  logic        i_vid_hsync,
  input  logic        i_vid_vsync,
  input  logic        i_vid_VDE,
  input  logic        i_enable,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic        o_box_valid
);

  localparam logic [X_BITS-1:0] X_MAX   = '1;
  localparam logic [Y_BITS-1:0] Y_MAX   = '1;
  localparam logic [15:0]       CNT_MAX = 16'hFFFF;
  localparam logic [15:0]       MIN_CNT = 16'(MIN_PIXELS);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  state_t            state;
  logic              vsync_q;
  logic              vde_q;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [X_BITS-1:0] xmin;
  logic [X_BITS-1:0] xmax;
  logic [Y_BITS-1:0] ymin;
  logic [Y_BITS-1:0] ymax;
  logic [15:0]       cnt;
  logic [X_BITS-1:0] bx0;
  logic [X_BITS-1:0] bx1;
  logic [Y_BITS-1:0] by0;
  logic [Y_BITS-1:0] by1;
  logic              box_valid;
  logic              on_box;

  logic vs_rise;
  logic vde_fall;
  logic marker;

  assign vs_rise  = i_vid_vsync & ~vsync_q;
  assign vde_fall = vde_q & ~i_vid_VDE;
  assign marker   = i_vid_VDE && (i_vid_data == MARK_COLOUR);

`ifdef SKIN_BBOX_CROSSHAIR_EN
  logic [X_BITS-1:0] cx;
  logic [Y_BITS-1:0] cy;
  logic [X_BITS:0]   x_sum;
  logic [Y_BITS:0]   y_sum;

  assign x_sum = {1'b0, xmin} + {1'b0, xmax};
  assign y_sum = {1'b0, ymin} + {1'b0, ymax};
`endif

  // Pixel position: x counts active pixels within a line, y counts lines; a frame boundary clears both.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vsync_q <= 1'b0;
      vde_q   <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      vsync_q <= i_vid_vsync;
      vde_q   <= i_vid_VDE;
      if (vs_rise) begin
        x <= '0;
        y <= '0;
      end else if (vde_fall) begin
        x <= '0;
        if (y != Y_MAX) y <= y + 1'b1;
      end else if (i_vid_VDE && (x != X_MAX)) begin
        x <= x + 1'b1;
      end
    end
  end

  // Frame state machine: accumulate marker extents, latch the box at each frame boundary.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= SYNC_WAIT;
      xmin      <= '1;
      xmax      <= '0;
      ymin      <= '1;
      ymax      <= '0;
      cnt       <= '0;
      bx0       <= '0;
      bx1       <= '0;
      by0       <= '0;
      by1       <= '0;
      box_valid <= 1'b0;
`ifdef SKIN_BBOX_CROSSHAIR_EN
      cx        <= '0;
      cy        <= '0;
`endif
    end else begin
      case (state)
        SYNC_WAIT: begin
          xmin <= '1;
          xmax <= '0;
          ymin <= '1;
          ymax <= '0;
          cnt  <= '0;
          if (vs_rise) state <= ACCUM;
        end
        ACCUM: begin
          if (vs_rise) begin
            bx0       <= xmin;
            bx1       <= xmax;
            by0       <= ymin;
            by1       <= ymax;
            box_valid <= (cnt >= MIN_CNT);
`ifdef SKIN_BBOX_CROSSHAIR_EN
            cx        <= x_sum[X_BITS:1];
            cy        <= y_sum[Y_BITS:1];
`endif
            xmin      <= '1;
            xmax      <= '0;
            ymin      <= '1;
            ymax      <= '0;
            cnt       <= '0;
          end else if (marker) begin
            if (x < xmin) xmin <= x;
            if (x > xmax) xmax <= x;
            if (y < ymin) ymin <= y;
            if (y > ymax) ymax <= y;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

  // Decide whether the current input pixel lies on the latched box outline (or crosshair).
  always_comb begin
    on_box = 1'b0;
    if (i_enable && box_valid && i_vid_VDE) begin
      if (((x == bx0) || (x == bx1)) && (y >= by0) && (y <= by1)) on_box = 1'b1;
      if (((y == by0) || (y == by1)) && (x >= bx0) && (x <= bx1)) on_box = 1'b1;
`ifdef SKIN_BBOX_CROSSHAIR_EN
      if ((x == cx) && (y >= by0) && (y <= by1)) on_box = 1'b1;
      if ((y == cy) && (x >= bx0) && (x <= bx1)) on_box = 1'b1;
`endif
    end
  end

  // Registered video output: overlay colour on box pixels, syncs delayed untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_vid_data  <= 24'h0;
      o_vid_hsync <= 1'b0;
      o_vid_vsync <= 1'b0;
      o_vid_VDE   <= 1'b0;
    end else begin
      o_vid_data  <= on_box ? BOX_COLOUR : i_vid_data;
      o_vid_hsync <= i_vid_hsync;
      o_vid_vsync <= i_vid_vsync;
      o_vid_VDE   <= i_vid_VDE;
    end
  end

  assign o_box_valid = box_valid;

endmodule

// File: doc/skin_bbox_overlay.md
# skin_bbox_overlay

- Post-processing stage directly downstream of the colour-change/skin-detection stage. Consumes its 24-bit video stream with hsync/vsync/VDE.
- Finds the bounding box of marker-coloured (skin-mask) pixels over each frame. At frame end it latches the box, then draws the box outline over the next frame's video.
- Registered pass-through with fixed 1-cycle latency. It feeds the HDMI output encoder.

## Interface

Parameters:
- X_BITS, 11, width of horizontal position counter (active pixels per line ≤ 2^X_BITS)
- Y_BITS, 11, width of vertical position counter
- MARK_COLOUR, 24'hFFFFFF, pixel value counted as a marker pixel
- BOX_COLOUR, 24'hFF0000, colour drawn on the outline
- MIN_PIXELS, 16, minimum marker count for a box to be valid

Ports:
- clk  input  1  pixel clock
- n_rst  input  1  reset; one clock, asynchronous, active-low
- i_vid_data  input  24  pixel from upstream stage
- i_vid_hsync  input  1  horizontal sync, passed through
- i_vid_vsync  input  1  vertical sync, active-high, passed through
- i_vid_VDE  input  1  active-video enable
- i_enable  input  1  1 = draw box, 0 = pure delayed pass-through
- o_vid_data  output  24  output pixel
- o_vid_hsync  output  1  i_vid_hsync delayed 1 cycle
- o_vid_vsync  output  1  i_vid_vsync delayed 1 cycle
- o_vid_VDE  output  1  i_vid_VDE delayed 1 cycle
- o_box_valid  output  1  latched box currently valid

## Operation

Position tracking:
- x counts active pixels. x is the column of the current pixel when i_vid_VDE=1, and increments after each VDE pixel. It saturates at 2^X_BITS−1 and clears to 0 on the VDE falling edge.
- y increments on each VDE falling edge and saturates at 2^Y_BITS−1.
- A vsync rising edge (registered previous vsync = 0, current = 1) is a frame boundary. It clears x and y to 0.

State machine:
- SYNC_WAIT (reset state): accumulators held cleared. On the first vsync rising edge, go to ACCUM. No box is latched on this edge, because the partial frame is discarded.
- ACCUM: for each VDE pixel with i_vid_data == MARK_COLOUR, update the accumulators:
  - xmin = min(xmin, x), xmax = max(xmax, x), ymin = min(ymin, y), ymax = max(ymax, y).
  - cnt += 1, saturating at 2^16−1.
- ACCUM at a vsync rising edge:
  - Latch bx0=xmin, bx1=xmax, by0=ymin, by1=ymax.
  - Set box_valid = (cnt ≥ MIN_PIXELS).
  - Reinitialise accumulators: xmin/ymin to all-ones, xmax/ymax to 0, cnt to 0.
  - Stay in ACCUM.
- A marker pixel on the same cycle as the vsync rising edge is not possible in legal video. If it occurs anyway, the latch uses the pre-update accumulator values and the pixel is dropped.

Drawing, evaluated on the input cycle and registered:
- on_box is 1 when all of the following hold:
  - i_enable and box_valid and i_vid_VDE;
  - and either (x==bx0 or x==bx1) and by0≤y≤by1, or (y==by0 or y==by1) and bx0≤x≤bx1.
- o_vid_data = on_box ? BOX_COLOUR : i_vid_data.
- A single-pixel box (bx0==bx1, by0==by1) draws exactly one pixel.

## Timing

- All outputs are registered. o_vid_* equal the inputs (or the overlay) exactly 1 clock later. Syncs and VDE are never modified.
- Reset values:
  - o_vid_data = 24'h0; o_vid_hsync = o_vid_vsync = o_vid_VDE = 0.
  - o_box_valid = 0; state = SYNC_WAIT.
  - x = y = 0; accumulators reinitialised; latched box = 0.
- o_box_valid updates 1 clock after the vsync rising edge cycle.
- The box latched at the end of frame N is drawn throughout frame N+1.
- Reset asserted mid-frame: all state clears immediately (asynchronous). The box is not drawn again until two vsync rising edges after reset release.
- i_enable changes take effect on the next input pixel; no frame alignment.

## Configuration

- SKIN_BBOX_CROSSHAIR_EN defined: additionally draws a centre crosshair when box_valid is set.
  - Centre cx = (bx0+bx1)>>1, cy = (by0+by1)>>1, computed at latch time with 1-bit-wider sums.
  - Pixels with (x==cx and by0≤y≤by1) or (y==cy and bx0≤x≤bx1) get BOX_COLOUR.
- Undefined: outline only; no centre registers are synthesised.

## Test plan

- Reset, then an 8×6 active frame containing no marker pixels, then a second frame → o_box_valid stays 0 and o_vid_data equals i_vid_data delayed 1 cycle on every pixel.
- MIN_PIXELS=4. Frame 1 (after the discarded first frame) has marker pixels at (2,1), (5,1), (2,4), (5,4) → after its vsync, o_box_valid=1. In frame 2, pixels (2..5,1), (2..5,4), (2,1..4), (5,1..4) output 24'hFF0000 and all others pass through.
- Same as the previous scenario but with only 3 marker pixels → o_box_valid=0 and no pixel is altered in the next frame.
- Valid box latched, then i_enable=0 for the whole frame → output is identical to the delayed input; o_box_valid remains 1.
- Assert n_rst=0 mid-frame while the box is drawn → outputs go to 0 immediately. The first vsync after release latches nothing; the box reappears only in the frame after the second vsync.
- With SKIN_BBOX_CROSSHAIR_EN defined and box (2,1)-(5,4) → the crosshair is at cx=3, cy=2: column 3 for y 1..4 and row 2 for x 2..5 are red.
